// File: rtl/cp0.sv
// Coprocessor-0: Status/Cause/EPC/EHB registers, Count/Compare timer and masked interrupt request.
// All state updates on posedge clk; MFC0 read path is combinational; hw_interrupt is one flop past IP.
module cp0 #(
    parameter logic [31:0] EHB_RESET = 32'h0000_0004,
    parameter int          TIMER_DIV = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exception,
    input  logic [31:0] cause,
    input  logic [31:0] epc,
    input  logic        eret,
    input  logic [4:0]  cp0_addr_i,
    input  logic [31:0] cp0_data_i,
    input  logic        cp0_we_i,
    input  logic [6:0]  irq_i,
    output logic [31:0] cp0_data_o,
    output logic [31:0] cp0_ehb,
    output logic [31:0] cp0_epc,
    output logic        hw_interrupt,
    output logic [31:0] hw_cause
);
    localparam int            PW        = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_DIV - 1);

    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic          ie_q, ie_d;
    logic          exl_q, exl_d;
    logic [7:0]    im_q, im_d;
    logic [4:0]    exccode_q, exccode_d;
    logic [31:0]   epc_q, epc_d;
    logic [31:0]   ehb_q, ehb_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tpend_q, tpend_d;
    logic [6:0]    irq_sync_q;
    logic          hw_int_q, hw_int_d;
    logic [31:0]   hw_cause_q, hw_cause_d;

    logic [7:0] ip;
    logic       wr;
    logic       tick;

    assign ip   = {tpend_q, irq_sync_q};
    // An exception cycle swallows any concurrent MTC0.
    assign wr   = cp0_we_i & ~exception;
    assign tick = (presc_q == PRESC_MAX);

    always_comb begin
        count_d    = count_q;
        compare_d  = compare_q;
        ie_d       = ie_q;
        exl_d      = exl_q;
        im_d       = im_q;
        exccode_d  = exccode_q;
        epc_d      = epc_q;
        ehb_d      = ehb_q;
        presc_d    = tick ? '0 : presc_q + PW'(1);
        tpend_d    = tpend_q | (count_q == compare_q);

        if (tick) begin
            count_d = count_q + 32'd1;
        end

        if (wr) begin
            case (cp0_addr_i)
                5'd9: begin
                    count_d = cp0_data_i;
                    presc_d = '0;
                end
                5'd11: begin
                    compare_d = cp0_data_i;
                    tpend_d   = 1'b0;
                end
                5'd12: begin
                    ie_d  = cp0_data_i[0];
                    exl_d = cp0_data_i[1];
                    im_d  = cp0_data_i[15:8];
                end
                5'd14:   epc_d = cp0_data_i;
                5'd15:   ehb_d = cp0_data_i;
                default: ;
            endcase
        end

        if (exception) begin
            epc_d     = epc;
            exccode_d = cause[6:2];
            exl_d     = 1'b1;
        end else if (eret) begin
            exl_d = 1'b0;
        end

        hw_int_d   = ie_q & ~exl_q & (|(ip & im_q));
        hw_cause_d = {16'h0, ip & im_q, 8'h00};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            compare_q  <= '0;
            ie_q       <= 1'b0;
            exl_q      <= 1'b0;
            im_q       <= '0;
            exccode_q  <= '0;
            epc_q      <= '0;
            ehb_q      <= EHB_RESET;
            presc_q    <= '0;
            tpend_q    <= 1'b0;
            irq_sync_q <= '0;
            hw_int_q   <= 1'b0;
            hw_cause_q <= '0;
        end else begin
            count_q    <= count_d;
            compare_q  <= compare_d;
            ie_q       <= ie_d;
            exl_q      <= exl_d;
            im_q       <= im_d;
            exccode_q  <= exccode_d;
            epc_q      <= epc_d;
            ehb_q      <= ehb_d;
            presc_q    <= presc_d;
            tpend_q    <= tpend_d;
            irq_sync_q <= irq_i;
            hw_int_q   <= hw_int_d;
            hw_cause_q <= hw_cause_d;
        end
    end

    always_comb begin
        cp0_data_o = 32'h0;
        case (cp0_addr_i)
            5'd9:    cp0_data_o = count_q;
            5'd11:   cp0_data_o = compare_q;
            5'd12:   cp0_data_o = {16'h0, im_q, 6'h0, exl_q, ie_q};
            5'd13:   cp0_data_o = {16'h0, ip, 1'b0, exccode_q, 2'b00};
            5'd14:   cp0_data_o = epc_q;
            5'd15:   cp0_data_o = ehb_q;
            default: cp0_data_o = 32'h0;
        endcase
    end

    assign cp0_ehb      = ehb_q;
    assign cp0_epc      = epc_q;
    assign hw_interrupt = hw_int_q;
    assign hw_cause     = hw_cause_q;
endmodule

// File: tb/tb_cp0.sv
// Directed bench for cp0: one instance with TIMER_DIV=1, one with TIMER_DIV=4, sharing all inputs.
module tb_cp0;
    logic        clk = 1'b0;
    logic        rst;
    logic        exception;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        eret;
    logic [4:0]  cp0_addr_i;
    logic [31:0] cp0_data_i;
    logic        cp0_we_i;
    logic [6:0]  irq_i;

    logic [31:0] data_o, ehb_o, epc_o, hcause_o;
    logic        hint_o;
    logic [31:0] data4_o, ehb4_o, epc4_o, hcause4_o;
    logic        hint4_o;

    int checks = 0;
    int errors = 0;

    cp0 #(.EHB_RESET(32'h4), .TIMER_DIV(1)) dut (
        .clk(clk), .rst(rst), .exception(exception), .cause(cause), .epc(epc), .eret(eret),
        .cp0_addr_i(cp0_addr_i), .cp0_data_i(cp0_data_i), .cp0_we_i(cp0_we_i), .irq_i(irq_i),
        .cp0_data_o(data_o), .cp0_ehb(ehb_o), .cp0_epc(epc_o),
        .hw_interrupt(hint_o), .hw_cause(hcause_o)
    );

    cp0 #(.EHB_RESET(32'h4), .TIMER_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .exception(exception), .cause(cause), .epc(epc), .eret(eret),
        .cp0_addr_i(cp0_addr_i), .cp0_data_i(cp0_data_i), .cp0_we_i(cp0_we_i), .irq_i(irq_i),
        .cp0_data_o(data4_o), .cp0_ehb(ehb4_o), .cp0_epc(epc4_o),
        .hw_interrupt(hint4_o), .hw_cause(hcause4_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        cp0_addr_i = a;
        cp0_data_i = d;
        cp0_we_i   = 1'b1;
        step();
        cp0_we_i   = 1'b0;
    endtask

    task automatic mfc0(input logic [4:0] a, output logic [31:0] d, output logic [31:0] d4);
        cp0_addr_i = a;
        #1;
        d  = data_o;
        d4 = data4_o;
    endtask

    task automatic test_reset();
        logic [31:0] r, r4;
        logic [31:0] exp_v [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4};
        logic [4:0]  addrs [6] = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};
        rst = 1'b1;
        step();
        step();
        for (int i = 0; i < 6; i++) begin
            mfc0(addrs[i], r, r4);
            checks++;
            if (r !== exp_v[i] || r4 !== exp_v[i]) begin
                errors++;
                $display("FAIL reset_reg%0d got %h/%h want %h", addrs[i], r, r4, exp_v[i]);
            end
        end
        mfc0(5'd3, r, r4);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL reset_unmapped got %h want 0", r);
        end
        checks++;
        if (hint_o !== 1'b0 || hcause_o !== 32'h0 || epc_o !== 32'h0 || ehb_o !== 32'h4) begin
            errors++;
            $display("FAIL reset_outputs got int=%b cause=%h epc=%h ehb=%h want 0/0/0/4",
                     hint_o, hcause_o, epc_o, ehb_o);
        end
        rst = 1'b0;
        mtc0(5'd11, 32'hFFFF_0000);
    endtask

    task automatic test_exception();
        logic [31:0] r, r4;
        exception = 1'b1;
        epc       = 32'h40;
        cause     = 32'h24;
        step();
        exception = 1'b0;
        checks++;
        if (epc_o !== 32'h40) begin
            errors++;
            $display("FAIL exc_epc got %h want 00000040", epc_o);
        end
        mfc0(5'd13, r, r4);
        checks++;
        if (r !== 32'h24) begin
            errors++;
            $display("FAIL exc_cause got %h want 00000024", r);
        end
        mfc0(5'd12, r, r4);
        checks++;
        if (r !== 32'h2) begin
            errors++;
            $display("FAIL exc_status got %h want 00000002", r);
        end
        eret = 1'b1;
        step();
        eret = 1'b0;
        mfc0(5'd12, r, r4);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL eret_status got %h want 00000000", r);
        end
    endtask

    task automatic test_timer();
        logic [31:0] r, r4;
        mtc0(5'd12, 32'h8001);
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd10);
        for (int i = 0; i < 9; i++) step();
        mfc0(5'd9, r, r4);
        checks++;
        if (r !== 32'd10 || hint_o !== 1'b0) begin
            errors++;
            $display("FAIL timer_count got count=%0d int=%b want 10/0", r, hint_o);
        end
        step();
        checks++;
        if (hint_o !== 1'b0) begin
            errors++;
            $display("FAIL timer_early got int=%b want 0", hint_o);
        end
        step();
        checks++;
        if (hint_o !== 1'b1 || hcause_o !== 32'h8000) begin
            errors++;
            $display("FAIL timer_fire got int=%b cause=%h want 1/00008000", hint_o, hcause_o);
        end
        mtc0(5'd11, 32'h1000_0000);
        step();
        checks++;
        if (hint_o !== 1'b0) begin
            errors++;
            $display("FAIL timer_clear got int=%b want 0", hint_o);
        end
    endtask

    task automatic test_irq_mask();
        mtc0(5'd12, 32'h0);
        irq_i = 7'h04;
        step();
        step();
        step();
        checks++;
        if (hint_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_masked got int=%b want 0", hint_o);
        end
        mtc0(5'd12, 32'h0401);
        checks++;
        if (hint_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_same_edge got int=%b want 0", hint_o);
        end
        step();
        checks++;
        if (hint_o !== 1'b1 || hcause_o !== 32'h400) begin
            errors++;
            $display("FAIL irq_unmasked got int=%b cause=%h want 1/00000400", hint_o, hcause_o);
        end
        exception = 1'b1;
        epc       = 32'h80;
        cause     = 32'h0;
        step();
        exception = 1'b0;
        step();
        checks++;
        if (hint_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_exl_drop got int=%b want 0", hint_o);
        end
        eret = 1'b1;
        step();
        eret = 1'b0;
        step();
        checks++;
        if (hint_o !== 1'b1) begin
            errors++;
            $display("FAIL irq_eret_reassert got int=%b want 1", hint_o);
        end
        irq_i = 7'h00;
        step();
        checks++;
        if (hint_o !== 1'b1) begin
            errors++;
            $display("FAIL irq_latency_hold got int=%b want 1", hint_o);
        end
        step();
        checks++;
        if (hint_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_latency_drop got int=%b want 0", hint_o);
        end
    endtask

    task automatic test_collisions();
        logic [31:0] r, r4;
        exception  = 1'b1;
        eret       = 1'b1;
        epc        = 32'h200;
        cause      = 32'h0;
        cp0_we_i   = 1'b1;
        cp0_addr_i = 5'd14;
        cp0_data_i = 32'h99;
        step();
        exception = 1'b0;
        eret      = 1'b0;
        cp0_we_i  = 1'b0;
        mfc0(5'd12, r, r4);
        checks++;
        if (epc_o !== 32'h200 || r !== 32'h0403) begin
            errors++;
            $display("FAIL collide_exc got epc=%h status=%h want 00000200/00000403", epc_o, r);
        end
        eret = 1'b1;
        step();
        eret = 1'b0;
        mtc0(5'd9, 32'h1234);
        mfc0(5'd9, r, r4);
        checks++;
        if (r !== 32'h1234 || r4 !== 32'h1234) begin
            errors++;
            $display("FAIL count_write got %h/%h want 00001234", r, r4);
        end
        step();
        mfc0(5'd9, r, r4);
        checks++;
        if (r !== 32'h1235 || r4 !== 32'h1234) begin
            errors++;
            $display("FAIL count_after_write got %h/%h want 00001235/00001234", r, r4);
        end
    endtask

    task automatic test_prescaler();
        logic [31:0] r, r4;
        logic        spurious;
        mtc0(5'd12, 32'h8001);
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'hFFFF_FFFF);
        spurious = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            spurious |= hint4_o;
        end
        mfc0(5'd9, r, r4);
        checks++;
        if (r4 !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL presc_hold got %h want ffffffff", r4);
        end
        step();
        spurious |= hint4_o;
        mfc0(5'd9, r, r4);
        checks++;
        if (r4 !== 32'h0) begin
            errors++;
            $display("FAIL presc_wrap got %h want 00000000", r4);
        end
        for (int i = 0; i < 20; i++) begin
            step();
            spurious |= hint4_o;
        end
        mfc0(5'd9, r, r4);
        checks++;
        if (r4 !== 32'd5 || spurious !== 1'b0) begin
            errors++;
            $display("FAIL presc_no_spurious got count=%0d spurious=%b want 5/0", r4, spurious);
        end
        step();
        step();
        checks++;
        if (hint4_o !== 1'b1 || hcause4_o !== 32'h8000) begin
            errors++;
            $display("FAIL presc_fire got int=%b cause=%h want 1/00008000", hint4_o, hcause4_o);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] r, r4;
        rst        = 1'b1;
        exception  = 1'b1;
        epc        = 32'hDEAD_0000;
        cp0_we_i   = 1'b1;
        cp0_addr_i = 5'd15;
        cp0_data_i = 32'h1111_1111;
        step();
        rst       = 1'b0;
        exception = 1'b0;
        cp0_we_i  = 1'b0;
        mfc0(5'd12, r, r4);
        checks++;
        if (epc_o !== 32'h0 || ehb_o !== 32'h4 || r !== 32'h0 || hint_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_midop got epc=%h ehb=%h status=%h int=%b want 0/4/0/0",
                     epc_o, ehb_o, r, hint_o);
        end
    endtask

    initial begin
        rst        = 1'b1;
        exception  = 1'b0;
        cause      = '0;
        epc        = '0;
        eret       = 1'b0;
        cp0_addr_i = '0;
        cp0_data_i = '0;
        cp0_we_i   = 1'b0;
        irq_i      = '0;
        test_reset();
        test_exception();
        test_timer();
        test_irq_mask();
        test_collisions();
        test_prescaler();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
